// File: rtl/grant_lock_mux_if.sv
// grant_lock_mux_if: port-side handshake, arbiter grant and registered output stage of grant_lock_mux
//   slave  : seen by grant_lock_mux (req/data/last/gnt/out_ready in; ready/out_*/owner/busy/err out)
//   master : seen by whatever drives the ports and consumes the output
interface grant_lock_mux_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W = 8
);
  logic [NUM_PORTS-1:0] req_i;
  logic [NUM_PORTS*DATA_W-1:0] data_i;
  logic [NUM_PORTS-1:0] last_i;
  logic [NUM_PORTS-1:0] gnt_i;
  logic [NUM_PORTS-1:0] ready_o;
  logic out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic out_last_o;
  logic out_ready_i;
  logic [NUM_PORTS-1:0] owner_o;
  logic busy_o;
  logic err_o;
  modport slave (
    input req_i, data_i, last_i, gnt_i, out_ready_i,
    output ready_o, out_valid_o, out_data_o, out_last_o, owner_o, busy_o, err_o
  );
  modport master (
    output req_i, data_i, last_i, gnt_i, out_ready_i,
    input ready_o, out_valid_o, out_data_o, out_last_o, owner_o, busy_o, err_o
  );
endinterface

// File: rtl/grant_lock_mux.sv
// grant_lock_mux: locks a one-hot arbiter grant as packet owner and steers its beats into one registered output stage
//   clk, reset : single clock, synchronous active-high reset
//   bus        : grant_lock_mux_if.slave (port handshake in, output stage out, owner/busy/err status)
module grant_lock_mux #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic reset,
  grant_lock_mux_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0] state_q, state_d;
  logic [NUM_PORTS-1:0] owner_q, owner_d;
  logic out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic out_last_q, out_last_d;
  logic err_q, err_d;
  logic [NUM_PORTS-1:0] gnt_low;
  logic gnt_one, gnt_multi, load_en, accept, sel_last, done;
  logic [NUM_PORTS-1:0] ready;
  logic [DATA_W-1:0] sel_data;
  // gnt & (gnt-1) clears the lowest set bit; nonzero means two or more bits set
  assign gnt_low = bus.gnt_i & (bus.gnt_i - NUM_PORTS'(1));
  assign gnt_one = |bus.gnt_i & ~|gnt_low;
  assign gnt_multi = |gnt_low;
  assign load_en = !out_valid_q | bus.out_ready_i;
  // owner_q is zero in IDLE, so ready is naturally zero there
  assign ready = owner_q & {NUM_PORTS{load_en}};
  assign accept = |(bus.req_i & ready);
  assign sel_last = |(bus.last_i & owner_q);
  assign done = accept & sel_last;
  always_comb begin
    sel_data = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      sel_data = sel_data | (bus.data_i[p*DATA_W +: DATA_W] & {DATA_W{owner_q[p]}});
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (gnt_one ? LOCKED : IDLE) : (done ? IDLE : LOCKED);
    owner_d = (state_q == IDLE) ? (gnt_one ? bus.gnt_i : '0) : (done ? '0 : owner_q);
    err_d = err_q | ((state_q == IDLE) & gnt_multi);
    out_valid_d = accept | (out_valid_q & !bus.out_ready_i);
    out_data_d = accept ? sel_data : out_data_q;
    out_last_d = accept ? sel_last : out_last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      err_q <= err_d;
    end
  end
  assign bus.ready_o = ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o = out_data_q;
  assign bus.out_last_o = out_last_q;
  assign bus.owner_o = owner_q;
  assign bus.busy_o = (state_q == LOCKED);
  assign bus.err_o = err_q;
endmodule

// File: tb/tb_grant_lock_mux.sv
// tb_grant_lock_mux: directed self-checking bench for grant_lock_mux
module tb_grant_lock_mux;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  grant_lock_mux_if #(.NUM_PORTS(4), .DATA_W(8)) bus ();
  grant_lock_mux #(.NUM_PORTS(4), .DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic set_data(input int p, input logic [7:0] d);
    bus.data_i[p*8 +: 8] = d;
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l);
    chk({tag, "_valid"}, 32'(bus.out_valid_o), 32'(v));
    chk({tag, "_data"}, 32'(bus.out_data_o), 32'(d));
    chk({tag, "_last"}, 32'(bus.out_last_o), 32'(l));
  endtask
  task automatic chk_ready(input string tag, input logic [3:0] r);
    #1;
    chk(tag, 32'(bus.ready_o), 32'(r));
  endtask
  initial begin
    reset = 1'b1;
    bus.req_i = '0;
    bus.data_i = '0;
    bus.last_i = '0;
    bus.gnt_i = '0;
    bus.out_ready_i = 1'b1;
    step();
    step();
    chk("rst_owner", 32'(bus.owner_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
    chk_out("rst", 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_all", {bus.ready_o, bus.owner_o, 3'(bus.out_valid_o), bus.out_data_o, 3'(bus.out_last_o), 3'(bus.busy_o), 3'(bus.err_o)}, 0);
    end
    // single packet on port 2
    bus.req_i = 4'b0100;
    bus.gnt_i = 4'b0100;
    set_data(2, 8'h11);
    chk_ready("sp_ready_idle", 4'b0000);
    step();
    chk("sp_owner", 32'(bus.owner_o), 32'h4);
    chk("sp_busy", 32'(bus.busy_o), 1);
    chk_ready("sp_ready1", 4'b0100);
    step();
    chk_out("sp_b1", 1'b1, 8'h11, 1'b0);
    set_data(2, 8'h22);
    step();
    chk_out("sp_b2", 1'b1, 8'h22, 1'b0);
    set_data(2, 8'h33);
    bus.last_i = 4'b0100;
    step();
    chk_out("sp_b3", 1'b1, 8'h33, 1'b1);
    chk("sp_end_busy", 32'(bus.busy_o), 0);
    chk("sp_end_owner", 32'(bus.owner_o), 0);
    bus.req_i = '0;
    bus.gnt_i = '0;
    bus.last_i = '0;
    step();
    chk("sp_drain_valid", 32'(bus.out_valid_o), 0);
    // pre-emption by port 0 while port 2 holds the lock
    bus.req_i = 4'b0100;
    bus.gnt_i = 4'b0100;
    set_data(2, 8'hB1);
    step();
    bus.req_i = 4'b0101;
    bus.gnt_i = 4'b0001;
    set_data(0, 8'hC0);
    chk_ready("pe_ready_a", 4'b0100);
    step();
    chk_out("pe_b1", 1'b1, 8'hB1, 1'b0);
    chk("pe_owner_a", 32'(bus.owner_o), 32'h4);
    set_data(2, 8'hB2);
    chk_ready("pe_ready_b", 4'b0100);
    step();
    chk_out("pe_b2", 1'b1, 8'hB2, 1'b0);
    set_data(2, 8'hB3);
    bus.last_i = 4'b0100;
    step();
    chk_out("pe_b3", 1'b1, 8'hB3, 1'b1);
    chk("pe_gap_owner", 32'(bus.owner_o), 0);
    bus.req_i = 4'b0001;
    bus.last_i = 4'b0001;
    chk_ready("pe_gap_ready", 4'b0000);
    step();
    chk("pe_p0_owner", 32'(bus.owner_o), 32'h1);
    chk_ready("pe_p0_ready", 4'b0001);
    step();
    chk_out("pe_c0", 1'b1, 8'hC0, 1'b1);
    chk("pe_c0_busy", 32'(bus.busy_o), 0);
    bus.req_i = '0;
    bus.gnt_i = '0;
    bus.last_i = '0;
    step();
    // backpressure on port 1
    bus.req_i = 4'b0010;
    bus.gnt_i = 4'b0010;
    set_data(1, 8'hA0);
    step();
    step();
    chk_out("bp_a0", 1'b1, 8'hA0, 1'b0);
    bus.out_ready_i = 1'b0;
    set_data(1, 8'hA1);
    for (int i = 0; i < 3; i++) begin
      chk_ready("bp_ready_stall", 4'b0000);
      step();
      chk_out("bp_hold", 1'b1, 8'hA0, 1'b0);
    end
    bus.out_ready_i = 1'b1;
    chk_ready("bp_ready_resume", 4'b0010);
    step();
    chk_out("bp_a1", 1'b1, 8'hA1, 1'b0);
    set_data(1, 8'hA2);
    step();
    chk_out("bp_a2", 1'b1, 8'hA2, 1'b0);
    set_data(1, 8'hA3);
    bus.last_i = 4'b0010;
    step();
    chk_out("bp_a3", 1'b1, 8'hA3, 1'b1);
    bus.req_i = '0;
    bus.gnt_i = '0;
    bus.last_i = '0;
    step();
    chk("bp_drain_valid", 32'(bus.out_valid_o), 0);
    // bad grant
    bus.req_i = 4'b0110;
    bus.gnt_i = 4'b0110;
    step();
    chk("bg_err", 32'(bus.err_o), 1);
    chk("bg_busy", 32'(bus.busy_o), 0);
    chk("bg_owner", 32'(bus.owner_o), 0);
    bus.req_i = '0;
    bus.gnt_i = '0;
    step();
    step();
    chk("bg_err_sticky", 32'(bus.err_o), 1);
    chk("bg_busy2", 32'(bus.busy_o), 0);
    // reset mid-packet on port 3
    bus.req_i = 4'b1000;
    bus.gnt_i = 4'b1000;
    set_data(3, 8'hD1);
    step();
    step();
    chk_out("rm_d1", 1'b1, 8'hD1, 1'b0);
    set_data(3, 8'hD2);
    step();
    chk_out("rm_d2", 1'b1, 8'hD2, 1'b0);
    reset = 1'b1;
    step();
    chk("rm_valid", 32'(bus.out_valid_o), 0);
    chk("rm_busy", 32'(bus.busy_o), 0);
    chk("rm_owner", 32'(bus.owner_o), 0);
    chk("rm_err", 32'(bus.err_o), 0);
    reset = 1'b0;
    bus.req_i = '0;
    bus.gnt_i = '0;
    step();
    chk("rm_idle_busy", 32'(bus.busy_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/grant_lock_mux.md
# grant_lock_mux

Downstream consumer of the fixed-priority one-hot arbiter. Latches the arbiter's one-hot grant as packet owner and holds it until that port sends its `last` beat. While locked, it steers the owner's data beats into one registered valid/ready output stage. Grant changes mid-packet are ignored, so multi-beat packets are never interleaved.

## Interface
- `NUM_PORTS`, 4: number of requesters; must be ≥ 2.
- `DATA_W`, 8: data beat width.

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_i`  in  NUM_PORTS  per-port valid; also drives the arbiter's request input.
- `data_i`  in  NUM_PORTS*DATA_W  port p's beat at bits [p*DATA_W +: DATA_W].
- `last_i`  in  NUM_PORTS  per-port end-of-packet flag, qualified by `req_i[p]`.
- `gnt_i`  in  NUM_PORTS  one-hot grant from the arbiter, combinational from `req_i`.
- `ready_o`  out  NUM_PORTS  per-port ready; a beat transfers when `req_i[p] & ready_o[p]`.
- `out_valid_o`  out  1  output beat valid.
- `out_data_o`  out  DATA_W  output beat data.
- `out_last_o`  out  1  output end-of-packet.
- `out_ready_i`  in  1  downstream ready.
- `owner_o`  out  NUM_PORTS  one-hot locked owner; 0 when idle.
- `busy_o`  out  1  high in LOCKED.
- `err_o`  out  1  sticky error: `gnt_i` had more than one bit set.

## Operation
- FSM states: IDLE and LOCKED.
- IDLE behaviour:
  - `ready_o` = 0 and `owner_o` = 0.
  - If `$countones(gnt_i) == 1`, set `owner_o <= gnt_i` and go to LOCKED.
  - If `gnt_i` is 0, stay in IDLE.
  - If more than one bit is set, stay in IDLE and set `err_o <= 1`.
- LOCKED behaviour:
  - Define `load_en = !out_valid_o | out_ready_i`.
  - `ready_o = owner_o & {NUM_PORTS{load_en}}`. Non-owner ports always see ready 0.
- Accepting a beat (`req_i[own] & ready_o[own]`):
  - Output register loads `data_i` slice and `last_i[own]`; `out_valid_o <= 1`.
  - If `last_i[own]` = 1, clear `owner_o` and return to IDLE.
- If `out_ready_i` = 1 and no beat is accepted, `out_valid_o <= 0`.
- While LOCKED, `gnt_i` is ignored entirely, even if a higher-priority port raises `req_i`.
- Owner drops `req_i` mid-packet: lock is held indefinitely; no timeout.
- Output register holds its value while `out_valid_o & !out_ready_i`. No beat is ever dropped or duplicated.
- `err_o` is cleared only by `reset`.

## Timing
- Reset values:
  - FSM = IDLE.
  - `owner_o` = 0, `busy_o` = 0, `ready_o` = 0.
  - `out_valid_o` = 0, `out_data_o` = 0, `out_last_o` = 0.
  - `err_o` = 0.
- Reset mid-packet: the lock and any pending output beat are discarded in the next cycle.
- Latency, request to lock: `gnt_i` seen in cycle N → `busy_o`/`owner_o` valid in N+1 → first beat can transfer in N+1.
- Latency, input to output: beat transferred in cycle M → `out_valid_o` high in M+1.
- Throughput: one beat per cycle while `out_ready_i` stays high.
- Packet gap: the `last` beat is accepted in cycle M, the FSM is IDLE in M+1, and the next lock is in M+2. Minimum one dead input cycle between packets.
- Single-beat packet (`last_i` high on the first beat): lock is held for exactly one cycle.
- `ready_o` depends combinationally on `out_valid_o` and `out_ready_i`.
- No combinational path exists from `req_i` or `gnt_i` to any output.

## Test plan
- Reset, then idle:
  - Stimulus: `req_i` = 0.
  - Response: all outputs 0 for 5 cycles; `ready_o` = 0.
- Single packet (NUM_PORTS=4, DATA_W=8):
  - Stimulus: `req_i` = 4'b0100, `gnt_i` = 4'b0100; data 0x11, 0x22, 0x33, with last on 0x33; `out_ready_i` = 1.
  - Response: `owner_o` = 4'b0100 one cycle after the grant; `out_data_o` = 0x11, 0x22, 0x33 on consecutive cycles; `out_last_o` only with 0x33; IDLE afterwards.
- Pre-emption ignored:
  - Stimulus: while port 2 is locked, assert `req_i[0]` and `gnt_i` = 4'b0001.
  - Response: `ready_o[0]` = 0 until port 2's last beat; port 0 locks 2 cycles after that last beat is accepted.
- Backpressure:
  - Stimulus: `out_ready_i` = 0 for 3 cycles mid-packet.
  - Response: `out_data_o` is stable, `ready_o[owner]` = 0, and no beat is lost. Sequence 0xA0..0xA3 emerges intact.
- Bad grant:
  - Stimulus: `gnt_i` = 4'b0110 in IDLE.
  - Response: `err_o` = 1 next cycle and stays high; FSM stays IDLE; `owner_o` = 0.
- Reset mid-packet:
  - Stimulus: assert `reset` after the 2nd beat.
  - Response: next cycle `out_valid_o` = 0, `busy_o` = 0, `owner_o` = 0.
